// File: rtl/osc_freq_meter.sv
// osc_freq_meter: counts synchronized osc_in rising edges per GATE_CYCLES window and strobes saturated (count - offset) on out_data/out_sat/out_valid; ports clk, reset, osc_in, enable, offset in; out_data, out_valid, out_sat out
module osc_freq_meter #(
  parameter int IO_B        = 16,
  parameter int GATE_CYCLES = 50000,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            osc_in,
  input  logic            enable,
  input  logic [IO_B-1:0] offset,
  output logic [IO_B-1:0] out_data,
  output logic            out_valid,
  output logic            out_sat
);
  localparam int CNT_B = $clog2(GATE_CYCLES) + 1;
  localparam int DW = (CNT_B > IO_B ? CNT_B : IO_B) + 1;
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic prev_q, rise, run, term, lo, hi;
  logic [CNT_B-1:0] gate_q, gate_d, edge_q, edge_d, raw;
  logic [DW-1:0] diff;
  logic [IO_B-1:0] data_q, data_d;
  logic valid_q, valid_d, sat_q, sat_d;
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], osc_in};
    rise = sync_q[SYNC_STAGES-1] & ~prev_q;
    run = state_q == RUN && enable;
    term = gate_q == CNT_B'(GATE_CYCLES - 1);
    state_d = enable ? RUN : IDLE;
    gate_d = run && !term ? gate_q + 1'b1 : '0;
    edge_d = run && !term ? edge_q + CNT_B'(rise) : '0;
    raw = edge_q + CNT_B'(rise);
    diff = DW'(raw) - DW'(offset);
    lo = DW'(raw) < DW'(offset);
    hi = !lo && (diff >> IO_B) != '0;
    valid_d = run && term;
    data_d = valid_d ? (lo ? '0 : hi ? '1 : diff[IO_B-1:0]) : data_q;
    sat_d = valid_d ? lo | hi : sat_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      state_q <= IDLE;
      gate_q <= '0;
      edge_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
      sat_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= sync_q[SYNC_STAGES-1];
      state_q <= state_d;
      gate_q <= gate_d;
      edge_q <= edge_d;
      data_q <= data_d;
      valid_q <= valid_d;
      sat_q <= sat_d;
    end
  end
  assign out_data = data_q;
  assign out_valid = valid_q;
  assign out_sat = sat_q;
endmodule

// File: tb/tb_osc_freq_meter.sv
// tb_osc_freq_meter: random and directed stimulus against a window-level reference model
module tb_osc_freq_meter;
  localparam int G = 100;
  logic clk = 1'b0, reset = 1'b1, osc_in = 1'b0, enable = 1'b0;
  logic [15:0] offset = '0, out_data;
  logic [3:0] offset4 = '0, out_data4;
  logic out_valid, out_sat, out_valid4, out_sat4;
  int checks = 0, failures = 0;
  int s1, s2, s3, running, pos, cnt;
  int e_valid, e_data, e_sat, e_data4, e_sat4;
  int cyc = 0, ph = 0, last_v = -1, prev_v = -1, en_cyc;
  always #5 clk = ~clk;
  osc_freq_meter #(.IO_B(16), .GATE_CYCLES(G), .SYNC_STAGES(2)) u_dut (
    .clk(clk), .reset(reset), .osc_in(osc_in), .enable(enable), .offset(offset),
    .out_data(out_data), .out_valid(out_valid), .out_sat(out_sat)
  );
  osc_freq_meter #(.IO_B(4), .GATE_CYCLES(G), .SYNC_STAGES(2)) u_dut4 (
    .clk(clk), .reset(reset), .osc_in(osc_in), .enable(enable), .offset(offset4),
    .out_data(out_data4), .out_valid(out_valid4), .out_sat(out_sat4)
  );
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  function automatic int clip(input int d, input int maxv);
    return d < 0 ? 0 : d > maxv ? maxv : d;
  endfunction
  task automatic step();
    int r, d;
    @(posedge clk);
    if (reset) begin
      s1 = 0; s2 = 0; s3 = 0; running = 0; pos = 0; cnt = 0;
      e_valid = 0; e_data = 0; e_sat = 0; e_data4 = 0; e_sat4 = 0;
    end else begin
      r = s2 & ~s3;
      e_valid = 0;
      if (running != 0 && enable) begin
        cnt += r;
        pos++;
        if (pos == G) begin
          e_valid = 1;
          d = cnt - int'(offset);
          e_data = clip(d, 65535);
          e_sat = (d < 0 || d > 65535) ? 1 : 0;
          d = cnt - int'(offset4);
          e_data4 = clip(d, 15);
          e_sat4 = (d < 0 || d > 15) ? 1 : 0;
          pos = 0;
          cnt = 0;
        end
      end else begin
        pos = 0;
        cnt = 0;
      end
      running = int'(enable);
      s3 = s2; s2 = s1; s1 = int'(osc_in);
    end
    #1;
    chk("valid", int'(out_valid), e_valid);
    chk("valid4", int'(out_valid4), e_valid);
    chk("data", int'(out_data), e_data);
    chk("sat", int'(out_sat), e_sat);
    chk("data4", int'(out_data4), e_data4);
    chk("sat4", int'(out_sat4), e_sat4);
    if (out_valid) begin
      prev_v = last_v;
      last_v = cyc;
    end
    cyc++;
    @(negedge clk);
  endtask
  task automatic run(input int n, input int per);
    for (int i = 0; i < n; i++) begin
      osc_in = (ph % per) < per / 2;
      ph++;
      step();
    end
  endtask
  task automatic run_to(input int t, input int per);
    for (int i = 0; i < 3 * G && pos != t; i++) run(1, per);
    chk("reach_gate_pos", pos, t);
  endtask
  initial begin
    repeat (3) step();
    chk("rst_data", int'(out_data), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_sat", int'(out_sat), 0);
    reset = 1'b0;
    offset = 16'd3;
    offset4 = 4'd0;
    en_cyc = cyc;
    enable = 1'b1;
    run(101, 10);
    chk("first_latency", last_v - en_cyc + 1, 101);
    run(100, 10);
    chk("period", last_v - prev_v, 100);
    chk("p1_data", int'(out_data), 7);
    chk("p1_sat", int'(out_sat), 0);
    chk("p1_data4", int'(out_data4), 10);
    offset = 16'd20;
    run(250, 10);
    chk("p2_data", int'(out_data), 0);
    chk("p2_sat", int'(out_sat), 1);
    chk("p2_data4", int'(out_data4), 10);
    chk("p2_sat4", int'(out_sat4), 0);
    run(250, 4);
    chk("p3_data4", int'(out_data4), 15);
    chk("p3_sat4", int'(out_sat4), 1);
    chk("p3_data", int'(out_data), 5);
    chk("p3_sat", int'(out_sat), 0);
    offset = '0;
    for (int k = 0; k < 12; k++) begin
      osc_in = 1'b0;
      run_to((95 + k) % G, 1 << 30);
      osc_in = 1'b1;
      step();
      osc_in = 1'b0;
      repeat (2 * G + 20) step();
    end
    run_to(50, 10);
    enable = 1'b0;
    run(5, 10);
    en_cyc = cyc;
    last_v = -1;
    enable = 1'b1;
    run(101, 10);
    chk("reenable_latency", last_v - en_cyc + 1, 101);
    run_to(G - 1, 10);
    run(1, 10);
    enable = 1'b0;
    run(3, 10);
    enable = 1'b1;
    run(150, 10);
    run_to(G - 1, 10);
    enable = 1'b0;
    run(3, 10);
    enable = 1'b1;
    run(150, 10);
    run_to(60, 10);
    reset = 1'b1;
    run(1, 10);
    chk("midreset_data", int'(out_data), 0);
    chk("midreset_valid", int'(out_valid), 0);
    chk("midreset_sat", int'(out_sat), 0);
    reset = 1'b0;
    run(250, 10);
    for (int blk = 0; blk < 15; blk++) begin
      int p;
      p = 10 + 40 * $urandom_range(0, 2);
      offset = 16'($urandom_range(0, 60));
      offset4 = 4'($urandom_range(0, 15));
      for (int i = 0; i < 1000; i++) begin
        osc_in = $urandom_range(0, 99) < p;
        if ($urandom_range(0, 399) == 0) enable = ~enable;
        if ($urandom_range(0, 199) == 0) offset = 16'($urandom_range(0, 60));
        reset = $urandom_range(0, 1999) == 0;
        step();
      end
      reset = 1'b0;
      enable = 1'b1;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
